// File: rtl/axis_replay_buffer.sv
// axis_replay_buffer
//   Single-clock AXI4-Stream store-and-forward buffer. One packet (tdata +
//   tstrb) is captured into on-chip RAM, then streamed out 1+cfg_replay
//   times. Oversize packets are swallowed and reported with stat_overflow.
//
// Ports
//   axis_aclk / axis_areset        clock, asynchronous active-high reset
//   s_axis_*                       ingress stream (tdata, tstrb, tvalid, tlast, tready)
//   m_axis_*                       egress stream (tdata, tstrb, tvalid, tlast, tready)
//   cfg_replay                     extra passes, sampled on the ingress tlast beat
//   stat_pkt_len                   beat count of the last stored packet
//   stat_overflow                  one-cycle pulse after an oversize packet is dropped
//   busy                           high while sending or dropping
module axis_replay_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_SIZE     = 4096,
    parameter int ADDR_WIDTH   = 12,
    parameter int REPLAY_WIDTH = 4
) (
    input  logic                      axis_aclk,
    input  logic                      axis_areset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic [REPLAY_WIDTH-1:0]   cfg_replay,
    output logic [ADDR_WIDTH:0]       stat_pkt_len,
    output logic                      stat_overflow,
    output logic                      busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WORD_W = DATA_WIDTH + STRB_W;
    localparam logic [ADDR_WIDTH-1:0]   PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]     LEN_ONE  = 1;
    localparam logic [REPLAY_WIDTH-1:0] PASS_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0]   PTR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [1:0] {S_FILL, S_DROP, S_SEND} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [REPLAY_WIDTH-1:0] r_pass;
    logic                    r_issue_done;
    logic [ADDR_WIDTH:0]     r_pkt_len;
    logic                    r_overflow;
    logic                    r_s_tready;
    logic [WORD_W-1:0]       r_mem [MEM_SIZE];

    logic [WORD_W-1:0]       r_word_p1;
    logic                    r_vld_p1;
    logic                    r_last_p1;
    logic                    r_final_p1;
    logic [WORD_W-1:0]       r_word_p2;
    logic                    r_vld_p2;
    logic                    r_last_p2;
    logic                    r_final_p2;

    logic                    w_in_fire;
    logic                    w_in_last;
    logic                    w_out_fire;
    logic                    w_done;
    logic                    w_adv_p1;
    logic                    w_adv_p2;
    logic                    w_issue;
    logic                    w_rd_last;
    logic                    w_rd_final;
    logic                    w_mem_we;
    logic                    w_busy;
    logic                    w_s_tready_nxt;

    assign w_in_fire  = s_axis_tvalid & r_s_tready;
    assign w_in_last  = w_in_fire & s_axis_tlast;
    assign w_out_fire = r_vld_p2 & m_axis_tready;
    assign w_done     = w_out_fire & r_last_p2 & r_final_p2;
    assign w_mem_we   = w_in_fire & (r_state == S_FILL);

    // Two-register read pipeline (RAM output, then egress register). Each
    // stage refills whenever the stage after it is empty or draining, which
    // gives one beat per cycle under constant ready and a built-in skid.
    assign w_adv_p2   = ~r_vld_p2 | m_axis_tready;
    assign w_adv_p1   = ~r_vld_p1 | w_adv_p2;
    assign w_issue    = (r_state == S_SEND) & ~r_issue_done & w_adv_p1;
    assign w_rd_last  = ({1'b0, r_rd_ptr} == (r_pkt_len - LEN_ONE));
    assign w_rd_final = w_rd_last & (r_pass == '0);

    // State register
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) r_state <= S_FILL;
        else             r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_in_last)                   w_state_nxt = S_SEND;
                else if (w_in_fire && (r_wr_ptr == PTR_LAST)) w_state_nxt = S_DROP;
            end
            S_DROP: if (w_in_last) w_state_nxt = S_FILL;
            S_SEND: if (w_done)    w_state_nxt = S_FILL;
            default:               w_state_nxt = S_FILL;
        endcase
    end

    // Output logic; ingress ready is registered so it stays low through reset
    always_comb begin
        w_busy         = (r_state != S_FILL);
        w_s_tready_nxt = (w_state_nxt != S_SEND);
    end

    // Packet RAM: no reset, synchronous read only when a beat is issued so
    // the read word holds while the pipeline is stalled.
    always_ff @(posedge axis_aclk) begin
        if (w_mem_we) r_mem[r_wr_ptr] <= {s_axis_tstrb, s_axis_tdata};
        if (w_issue)  r_word_p1 <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_s_tready   <= 1'b0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pass       <= '0;
            r_issue_done <= 1'b1;
            r_pkt_len    <= '0;
            r_vld_p1     <= 1'b0;
            r_last_p1    <= 1'b0;
            r_final_p1   <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_last_p2    <= 1'b0;
            r_final_p2   <= 1'b0;
            r_word_p2    <= '0;
        end else begin
            r_s_tready <= w_s_tready_nxt;
            r_overflow <= (r_state == S_DROP) & w_in_last;

            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (s_axis_tlast) begin
                    r_pkt_len    <= {1'b0, r_wr_ptr} + LEN_ONE;
                    r_pass       <= cfg_replay;
                    r_issue_done <= 1'b0;
                end
            end
            if ((r_state == S_DROP) && w_in_last) r_wr_ptr <= '0;
            if (w_done) r_wr_ptr <= '0;

            // Read issue: wrap to beat 0 at the end of each pass, stop after the last pass
            if (w_issue) begin
                if (w_rd_last) begin
                    r_rd_ptr <= '0;
                    if (r_pass == '0) r_issue_done <= 1'b1;
                    else              r_pass       <= r_pass - PASS_ONE;
                end else begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end

            // ---- stage p1: RAM read result ----
            if (w_adv_p1) begin
                r_vld_p1   <= w_issue;
                r_last_p1  <= w_rd_last;
                r_final_p1 <= w_rd_final;
            end

            // ---- stage p2: egress register ----
            if (w_adv_p2) begin
                r_vld_p2   <= r_vld_p1;
                r_last_p2  <= r_last_p1;
                r_final_p2 <= r_final_p1;
                r_word_p2  <= r_word_p1;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_vld_p2;
    assign m_axis_tlast  = r_last_p2;
    assign m_axis_tdata  = r_word_p2[DATA_WIDTH-1:0];
    assign m_axis_tstrb  = r_word_p2[WORD_W-1:DATA_WIDTH];
    assign stat_pkt_len  = r_pkt_len;
    assign stat_overflow = r_overflow;
    assign busy          = w_busy;

endmodule

// File: tb/tb_axis_replay_buffer.sv
module tb_axis_replay_buffer;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MS = 16;
    localparam int AW = 4;
    localparam int RW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tstrb = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [RW-1:0] cfg_replay = '0;
    logic [AW:0]   stat_pkt_len;
    logic          stat_overflow;
    logic          busy;

    axis_replay_buffer #(
        .DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .REPLAY_WIDTH(RW)
    ) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .cfg_replay(cfg_replay), .stat_pkt_len(stat_pkt_len),
        .stat_overflow(stat_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    fire_cyc_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ovf_cnt = 0;
    logic  stall_mode = 1'b0;
    logic  tog = 1'b0;
    logic  lat_arm = 1'b0;
    int    lat_cyc = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress ready: constant high, or alternating 1,0,1,0 in stall mode
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            m_tready = stall_mode ? tog : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        beat_t e;
        beat_t a;
        forever begin
            @(negedge clk);
            a = '{d: m_tdata, s: m_tstrb, l: m_tlast};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (lat_arm && m_tvalid) begin
                    lat_cyc = cyc;
                    lat_arm = 1'b0;
                end
                if (prev_stall) begin
                    checks++;
                    if (!m_tvalid || a != prev_beat) begin
                        errors++;
                        $display("FAIL stall_hold actual vld=%0b beat=%h required vld=1 beat=%h",
                                 m_tvalid, a, prev_beat);
                    end
                end
                if (m_tvalid && m_tready) begin
                    fire_cyc_q.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat actual=%h required=none", a);
                    end else begin
                        e = exp_q.pop_front();
                        if (a != e) begin
                            errors++;
                            $display("FAIL egress_beat actual d=%h s=%h l=%0b required d=%h s=%h l=%0b",
                                     a.d, a.s, a.l, e.d, e.s, e.l);
                        end
                    end
                end
                if (stat_overflow) ovf_cnt++;
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = a;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one packet base, base+1, ... ; optionally queue its expected egress
    task automatic send_pkt(input logic [DW-1:0] base, input int len, input logic [SW-1:0] strb,
                            input logic [RW-1:0] replay, input bit expect_out, output int acc_cyc);
        bit ok;
        cfg_replay = replay;
        if (expect_out) begin
            for (int p = 0; p <= int'(replay); p++)
                for (int i = 0; i < len; i++)
                    exp_q.push_back('{d: base + DW'(i), s: strb, l: (i == len - 1)});
        end
        for (int i = 0; i < len; i++) begin
            s_tdata  = base + DW'(i);
            s_tstrb  = strb;
            s_tlast  = (i == len - 1);
            s_tvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (s_tready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL s_accept_timeout actual=not_ready required=ready");
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_idle(input string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n;
        #1 rst = 1'b1;
        #2;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", stat_overflow, 0);
        chk("rst_pkt_len", stat_pkt_len, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_s_tready_low", s_tready, 0);
        @(posedge clk);
        #1;
        chk("rel_s_tready_high", s_tready, 1);

        // Test 1: 4 beats, send once, latency N+2
        send_pkt(32'hA0, 4, 4'hF, 0, 1'b1, acc);
        lat_arm = 1'b1;
        @(negedge clk);
        chk("t1_pkt_len", stat_pkt_len, 4);
        chk("t1_busy", busy, 1);
        chk("t1_s_tready", s_tready, 0);
        wait_idle("t1");
        chk("t1_latency", lat_cyc - acc, 2);

        // Test 2: 3 beats, replay 2, back-to-back
        fire_cyc_q.delete();
        send_pkt(32'h11, 3, 4'hF, 2, 1'b1, acc);
        wait_idle("t2");
        chk("t2_beats", fire_cyc_q.size(), 9);
        if (fire_cyc_q.size() == 9) chk("t2_span", fire_cyc_q[8] - fire_cyc_q[0], 8);

        // Test 3: alternating egress ready
        fire_cyc_q.delete();
        stall_mode = 1'b1;
        send_pkt(32'hA0, 4, 4'hF, 0, 1'b1, acc);
        wait_idle("t3");
        stall_mode = 1'b0;
        chk("t3_beats", fire_cyc_q.size(), 4);
        if (fire_cyc_q.size() == 4) chk("t3_span", fire_cyc_q[3] - fire_cyc_q[0], 6);

        // Test 4: oversize drop, then a full-size packet
        fire_cyc_q.delete();
        ovf_cnt = 0;
        send_pkt(32'h100, 20, 4'hF, 0, 1'b0, acc);
        @(negedge clk);
        chk("t4_ovf_pulse", stat_overflow, 1);
        chk("t4_len_kept", stat_pkt_len, 4);
        @(negedge clk);
        chk("t4_ovf_end", stat_overflow, 0);
        repeat (4) @(negedge clk);
        chk("t4_no_egress", fire_cyc_q.size(), 0);
        chk("t4_ovf_count", ovf_cnt, 1);
        @(posedge clk);
        #1;
        send_pkt(32'h200, 16, 4'hA, 0, 1'b1, acc);
        @(negedge clk);
        chk("t4_full_len", stat_pkt_len, 16);
        wait_idle("t4");
        chk("t4_full_beats", fire_cyc_q.size(), 16);

        // Test 5: reset during pass 2
        fire_cyc_q.delete();
        send_pkt(32'h11, 3, 4'hF, 2, 1'b1, acc);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (fire_cyc_q.size() >= 4) break;
        end
        chk("t5_reached_pass2", fire_cyc_q.size() >= 4, 1);
        @(posedge clk);
        #2;
        chk("t5_pre_valid", m_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("t5_async_vld", m_tvalid, 0);
        chk("t5_rst_ready", s_tready, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_rel_ready_low", s_tready, 0);
        @(posedge clk);
        #1;
        chk("t5_rel_ready_high", s_tready, 1);
        fire_cyc_q.delete();
        send_pkt(32'h55, 2, 4'h3, 0, 1'b1, acc);
        wait_idle("t5");
        chk("t5_beats", fire_cyc_q.size(), 2);

        // Test 6: single beat, replay 1
        fire_cyc_q.delete();
        send_pkt(32'hDEADBEEF, 1, 4'h5, 1, 1'b1, acc);
        wait_idle("t6");
        chk("t6_beats", fire_cyc_q.size(), 2);
        if (fire_cyc_q.size() == 2) chk("t6_span", fire_cyc_q[1] - fire_cyc_q[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
